// File: rtl/m_controller_pkg.sv
// Shared definitions for the M-extension controller.
// The block below holds the m_definitions encodings: mux select widths and codes,
// funct3 op constants and the controller state encoding.

`ifndef M_DEFINITIONS_SVH
`define M_DEFINITIONS_SVH
`define MUX_R_LENGTH     3
`define MUX_D_LENGTH     2
`define MUX_Z_LENGTH     2
`define MUX_MULTA_LENGTH 2
`define MUX_MULTB_LENGTH 2
`endif

package m_controller_pkg;

  // Remainder register (R) select codes
  localparam logic [`MUX_R_LENGTH-1:0] MUX_R_KEEP       = 3'd0;
  localparam logic [`MUX_R_LENGTH-1:0] MUX_R_A          = 3'd1;
  localparam logic [`MUX_R_LENGTH-1:0] MUX_R_A_NEG      = 3'd2;
  localparam logic [`MUX_R_LENGTH-1:0] MUX_R_MULT_LOWER = 3'd3;
  localparam logic [`MUX_R_LENGTH-1:0] MUX_R_SUB_KEEP   = 3'd4;

  // Divisor register (D) select codes
  localparam logic [`MUX_D_LENGTH-1:0] MUX_D_KEEP  = 2'd0;
  localparam logic [`MUX_D_LENGTH-1:0] MUX_D_B     = 2'd1;
  localparam logic [`MUX_D_LENGTH-1:0] MUX_D_B_NEG = 2'd2;
  localparam logic [`MUX_D_LENGTH-1:0] MUX_D_SHR   = 2'd3;

  // Quotient register (Z) select codes
  localparam logic [`MUX_Z_LENGTH-1:0] MUX_Z_KEEP       = 2'd0;
  localparam logic [`MUX_Z_LENGTH-1:0] MUX_Z_ZERO       = 2'd1;
  localparam logic [`MUX_Z_LENGTH-1:0] MUX_Z_MULT_UPPER = 2'd2;
  localparam logic [`MUX_Z_LENGTH-1:0] MUX_Z_SHL_ADD    = 2'd3;

  // Multiplier operand select codes
  localparam logic [`MUX_MULTA_LENGTH-1:0] MUX_MULTA_ZERO     = 2'd0;
  localparam logic [`MUX_MULTA_LENGTH-1:0] MUX_MULTA_UNSIGNED = 2'd1;
  localparam logic [`MUX_MULTA_LENGTH-1:0] MUX_MULTA_SIGNED   = 2'd2;
  localparam logic [`MUX_MULTB_LENGTH-1:0] MUX_MULTB_ZERO     = 2'd0;
  localparam logic [`MUX_MULTB_LENGTH-1:0] MUX_MULTB_UNSIGNED = 2'd1;
  localparam logic [`MUX_MULTB_LENGTH-1:0] MUX_MULTB_SIGNED   = 2'd2;

  // RV32M funct3 op codes
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Controller state encoding
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    MUL_OPS  = 3'd2,
    MUL_PROD = 3'd3,
    MUL_WB   = 3'd4,
    DIV_ITER = 3'd5,
    DONE     = 3'd6
  } m_state_t;

  // Op classification derived from funct3
  typedef struct packed {
    logic is_mul;
    logic is_signed_div;
    logic upper_half;
    logic a_signed;
    logic b_signed;
  } op_dec_t;

  // Full set of controller outputs, registered as one bundle
  typedef struct packed {
    logic [`MUX_MULTA_LENGTH-1:0] mux_multA;
    logic [`MUX_MULTB_LENGTH-1:0] mux_multB;
    logic [`MUX_R_LENGTH-1:0]     mux_R;
    logic [`MUX_D_LENGTH-1:0]     mux_D;
    logic [`MUX_Z_LENGTH-1:0]     mux_Z;
    logic                         busy;
    logic                         done;
    logic                         result_sel;
    logic                         negate_result;
  } ctl_out_t;

  // Output values in IDLE, which are also the reset values
  localparam ctl_out_t CTL_IDLE = '{
    mux_multA:     MUX_MULTA_ZERO,
    mux_multB:     MUX_MULTB_ZERO,
    mux_R:         MUX_R_KEEP,
    mux_D:         MUX_D_KEEP,
    mux_Z:         MUX_Z_KEEP,
    busy:          1'b0,
    done:          1'b0,
    result_sel:    1'b0,
    negate_result: 1'b0
  };

endpackage

// File: rtl/m_controller.sv
// Sequencing FSM for the M-extension datapath: accepts one RV32M op via
// start/done, steps the multiplier or restoring divider and drives all
// register/multiplier mux selects. Outputs are registered and decoded from
// the next state so they line up with the state they describe.

module m_controller
  import m_controller_pkg::*;
#(
  parameter int DIV_STEPS = 32,
  parameter int MUL_WAIT  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [2:0]                   funct3,
  input  logic                         rs1_sign,
  input  logic                         rs2_sign,
  input  logic                         rs2_zero,
  input  logic                         flush,
  output logic [`MUX_MULTA_LENGTH-1:0] mux_multA,
  output logic [`MUX_MULTB_LENGTH-1:0] mux_multB,
  output logic [`MUX_R_LENGTH-1:0]     mux_R,
  output logic [`MUX_D_LENGTH-1:0]     mux_D,
  output logic [`MUX_Z_LENGTH-1:0]     mux_Z,
  output logic                         busy,
  output logic                         done,
  output logic                         result_sel,
  output logic                         negate_result
);

  // One counter serves both the divide iterations and the multiplier wait
  localparam int CNT_MAX = (DIV_STEPS > MUL_WAIT + 1) ? DIV_STEPS : MUL_WAIT + 1;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_STEPS - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_WAIT);

  m_state_t         state_r, state_s;
  logic [2:0]       funct3_r, funct3_s;
  logic             rs1_sign_r, rs1_sign_s;
  logic             rs2_sign_r, rs2_sign_s;
  logic             rs2_zero_r, rs2_zero_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  ctl_out_t         out_r, out_s;

  function automatic op_dec_t op_decode(input logic [2:0] f3);
    op_dec_t d;
    d.is_mul        = ~f3[2];
    d.is_signed_div = f3[2] & ~f3[0];
    d.upper_half    = ~f3[2] & (f3[1:0] != 2'b00);
    d.a_signed      = ~f3[2] & (f3[1] ^ f3[0]);
    d.b_signed      = ~f3[2] & ~f3[1] & f3[0];
    return d;
  endfunction

  function automatic ctl_out_t decode_outputs(input m_state_t st, input logic [2:0] f3,
                                              input logic s1, input logic s2, input logic z);
    ctl_out_t o;
    op_dec_t  op;
    op = op_decode(f3);
    o  = CTL_IDLE;
    case (st)
      IDLE: begin
        o = CTL_IDLE;
      end
      LOAD: begin
        o.busy  = 1'b1;
        o.mux_Z = MUX_Z_ZERO;
        if (op.is_signed_div) begin
          o.mux_R = s1 ? MUX_R_A_NEG : MUX_R_A;
          o.mux_D = s2 ? MUX_D_B_NEG : MUX_D_B;
        end else begin
          o.mux_R = MUX_R_A;
          o.mux_D = MUX_D_B;
        end
      end
      MUL_OPS, MUL_PROD, MUL_WB: begin
        o.busy      = 1'b1;
        o.mux_multA = op.a_signed ? MUX_MULTA_SIGNED : MUX_MULTA_UNSIGNED;
        o.mux_multB = op.b_signed ? MUX_MULTB_SIGNED : MUX_MULTB_UNSIGNED;
        if (st != MUL_WB) begin
          o.mux_R = MUX_R_KEEP;
        end else if (op.upper_half) begin
          o.mux_Z = MUX_Z_MULT_UPPER;
        end else begin
          o.mux_R = MUX_R_MULT_LOWER;
        end
      end
      DIV_ITER: begin
        o.busy  = 1'b1;
        o.mux_R = MUX_R_SUB_KEEP;
        o.mux_Z = MUX_Z_SHL_ADD;
        o.mux_D = MUX_D_SHR;
      end
      DONE: begin
        o.done       = 1'b1;
        // MUL leaves its answer in R; REM/REMU leave the remainder in R
        o.result_sel = (op.is_mul & ~op.upper_half) | (f3[2] & f3[1]);
        case (f3)
          F3_DIV:  o.negate_result = (s1 ^ s2) & ~z;
          F3_REM:  o.negate_result = s1;
          default: o.negate_result = 1'b0;
        endcase
      end
      default: begin
        o = CTL_IDLE;
      end
    endcase
    return o;
  endfunction

  // Next-state, operand latch and step counter logic
  always_comb begin
    state_s    = state_r;
    funct3_s   = funct3_r;
    rs1_sign_s = rs1_sign_r;
    rs2_sign_s = rs2_sign_r;
    rs2_zero_s = rs2_zero_r;
    cnt_s      = cnt_r;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            funct3_s   = funct3;
            rs1_sign_s = rs1_sign;
            rs2_sign_s = rs2_sign;
            rs2_zero_s = rs2_zero;
            state_s    = LOAD;
          end else begin
            state_s = IDLE;
          end
        end
        LOAD: begin
          cnt_s   = '0;
          state_s = funct3_r[2] ? DIV_ITER : MUL_OPS;
        end
        MUL_OPS: begin
          if (cnt_r == MUL_LAST) begin
            cnt_s   = '0;
            state_s = MUL_PROD;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        MUL_PROD: state_s = MUL_WB;
        MUL_WB:   state_s = DONE;
        DIV_ITER: begin
          if (cnt_r == DIV_LAST) begin
            state_s = DONE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Decode the outputs belonging to the upcoming state
  always_comb begin
    out_s = decode_outputs(state_s, funct3_s, rs1_sign_s, rs2_sign_s, rs2_zero_s);
  end

  // State, operand and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      funct3_r   <= 3'b000;
      rs1_sign_r <= 1'b0;
      rs2_sign_r <= 1'b0;
      rs2_zero_r <= 1'b0;
      cnt_r      <= '0;
      out_r      <= CTL_IDLE;
    end else begin
      state_r    <= state_s;
      funct3_r   <= funct3_s;
      rs1_sign_r <= rs1_sign_s;
      rs2_sign_r <= rs2_sign_s;
      rs2_zero_r <= rs2_zero_s;
      cnt_r      <= cnt_s;
      out_r      <= out_s;
    end
  end

  assign mux_multA     = out_r.mux_multA;
  assign mux_multB     = out_r.mux_multB;
  assign mux_R         = out_r.mux_R;
  assign mux_D         = out_r.mux_D;
  assign mux_Z         = out_r.mux_Z;
  assign busy          = out_r.busy;
  assign done          = out_r.done;
  assign result_sel    = out_r.result_sel;
  assign negate_result = out_r.negate_result;

endmodule

// File: tb/tb_m_controller.sv
// Directed testbench for m_controller: steps through reset, each op class,
// flush and back-to-back issue, checking every output at hand-derived cycles.

module tb_m_controller;
  import m_controller_pkg::*;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         start;
  logic [2:0]                   funct3;
  logic                         rs1_sign;
  logic                         rs2_sign;
  logic                         rs2_zero;
  logic                         flush;
  logic [`MUX_MULTA_LENGTH-1:0] mux_multA;
  logic [`MUX_MULTB_LENGTH-1:0] mux_multB;
  logic [`MUX_R_LENGTH-1:0]     mux_R;
  logic [`MUX_D_LENGTH-1:0]     mux_D;
  logic [`MUX_Z_LENGTH-1:0]     mux_Z;
  logic                         busy;
  logic                         done;
  logic                         result_sel;
  logic                         negate_result;

  int checks = 0;
  int errors = 0;

  m_controller #(.DIV_STEPS(32), .MUL_WAIT(0)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_sign(rs1_sign), .rs2_sign(rs2_sign), .rs2_zero(rs2_zero), .flush(flush),
    .mux_multA(mux_multA), .mux_multB(mux_multB), .mux_R(mux_R), .mux_D(mux_D),
    .mux_Z(mux_Z), .busy(busy), .done(done), .result_sel(result_sel),
    .negate_result(negate_result)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag,
                            input logic [`MUX_R_LENGTH-1:0] r,
                            input logic [`MUX_D_LENGTH-1:0] d,
                            input logic [`MUX_Z_LENGTH-1:0] z,
                            input logic [`MUX_MULTA_LENGTH-1:0] a,
                            input logic [`MUX_MULTB_LENGTH-1:0] b,
                            input logic bsy, input logic dn,
                            input logic rs, input logic ng);
    chk({tag, "/mux_R"},     32'(mux_R),         32'(r));
    chk({tag, "/mux_D"},     32'(mux_D),         32'(d));
    chk({tag, "/mux_Z"},     32'(mux_Z),         32'(z));
    chk({tag, "/mux_multA"}, 32'(mux_multA),     32'(a));
    chk({tag, "/mux_multB"}, 32'(mux_multB),     32'(b));
    chk({tag, "/busy"},      32'(busy),          32'(bsy));
    chk({tag, "/done"},      32'(done),          32'(dn));
    chk({tag, "/result_sel"},32'(result_sel),    32'(rs));
    chk({tag, "/negate"},    32'(negate_result), 32'(ng));
  endtask

  task automatic expect_idle(input string tag);
    expect_out(tag, MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP, MUX_MULTA_ZERO, MUX_MULTB_ZERO,
               1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one cycle; returns positioned in cycle 1 (LOAD)
  task automatic issue(input logic [2:0] f3, input logic s1, input logic s2, input logic z);
    funct3   = f3;
    rs1_sign = s1;
    rs2_sign = s2;
    rs2_zero = z;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Full divide-class op: LOAD selects, 32 iterations, DONE at cycle 34, then IDLE
  task automatic run_div(input string tag, input logic [2:0] f3, input logic s1,
                         input logic s2, input logic z,
                         input logic [`MUX_R_LENGTH-1:0] load_r,
                         input logic [`MUX_D_LENGTH-1:0] load_d,
                         input logic rs, input logic ng);
    issue(f3, s1, s2, z);
    expect_out({tag, "_load"}, load_r, load_d, MUX_Z_ZERO, MUX_MULTA_ZERO, MUX_MULTB_ZERO,
               1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 33; i++) begin
      tick();
      chk({tag, "_iter_R"}, 32'(mux_R), 32'(MUX_R_SUB_KEEP));
      chk({tag, "_iter_D"}, 32'(mux_D), 32'(MUX_D_SHR));
      chk({tag, "_iter_Z"}, 32'(mux_Z), 32'(MUX_Z_SHL_ADD));
      chk({tag, "_iter_done"}, 32'(done), 32'(1'b0));
    end
    tick();
    expect_out({tag, "_done"}, MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP, MUX_MULTA_ZERO,
               MUX_MULTB_ZERO, 1'b0, 1'b1, rs, ng);
    tick();
    expect_idle({tag, "_after"});
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; flush = 1'b0; funct3 = F3_MUL;
    rs1_sign = 1'b0; rs2_sign = 1'b0; rs2_zero = 1'b0;

    // Reset held with start asserted: stays IDLE, never signals done
    tick();
    expect_idle("reset");
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("reset_no_done", 32'(done), 32'(1'b0));
    end
    reset = 1'b0; start = 1'b0;
    tick();
    expect_idle("post_reset");

    // MULH -2 * 3: signed x signed, upper half into Z
    issue(F3_MULH, 1'b1, 1'b0, 1'b0);
    expect_out("mulh_load", MUX_R_A, MUX_D_B, MUX_Z_ZERO, MUX_MULTA_ZERO, MUX_MULTB_ZERO,
               1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("mulh_ops", MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP, MUX_MULTA_SIGNED,
               MUX_MULTB_SIGNED, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("mulh_prod", MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP, MUX_MULTA_SIGNED,
               MUX_MULTB_SIGNED, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("mulh_wb", MUX_R_KEEP, MUX_D_KEEP, MUX_Z_MULT_UPPER, MUX_MULTA_SIGNED,
               MUX_MULTB_SIGNED, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("mulh_done", MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP, MUX_MULTA_ZERO,
               MUX_MULTB_ZERO, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expect_idle("mulh_after");

    // Divide class: signs, divide-by-zero and overflow boundaries
    run_div("div_m7_2",  F3_DIV,  1'b1, 1'b0, 1'b0, MUX_R_A_NEG, MUX_D_B,     1'b0, 1'b1);
    run_div("rem_m7_2",  F3_REM,  1'b1, 1'b0, 1'b0, MUX_R_A_NEG, MUX_D_B,     1'b1, 1'b1);
    run_div("divu_by0",  F3_DIVU, 1'b1, 1'b0, 1'b1, MUX_R_A,     MUX_D_B,     1'b0, 1'b0);
    run_div("div_by0",   F3_DIV,  1'b1, 1'b0, 1'b1, MUX_R_A_NEG, MUX_D_B,     1'b0, 1'b0);
    run_div("div_ovf",   F3_DIV,  1'b1, 1'b1, 1'b0, MUX_R_A_NEG, MUX_D_B_NEG, 1'b0, 1'b0);
    run_div("remu",      F3_REMU, 1'b1, 1'b1, 1'b0, MUX_R_A,     MUX_D_B,     1'b1, 1'b0);

    // Flush at cycle 10 of a DIV, with start also high: flush wins
    issue(F3_DIV, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 10; i++) begin
      tick();
    end
    chk("flush_pre_busy", 32'(busy), 32'(1'b1));
    flush = 1'b1; start = 1'b1;
    tick();
    expect_idle("flush_idle");
    flush = 1'b0;

    // Start right after flush: MUL accepted
    funct3 = F3_MUL; rs1_sign = 1'b0; rs2_sign = 1'b0; rs2_zero = 1'b0;
    tick();
    start = 1'b0;
    expect_out("mul_load", MUX_R_A, MUX_D_B, MUX_Z_ZERO, MUX_MULTA_ZERO, MUX_MULTB_ZERO,
               1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("mul_ops", MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP, MUX_MULTA_UNSIGNED,
               MUX_MULTB_UNSIGNED, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    expect_out("mul_wb", MUX_R_MULT_LOWER, MUX_D_KEEP, MUX_Z_KEEP, MUX_MULTA_UNSIGNED,
               MUX_MULTB_UNSIGNED, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("mul_done", MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP, MUX_MULTA_ZERO,
               MUX_MULTB_ZERO, 1'b0, 1'b1, 1'b1, 1'b0);

    // Back-to-back: MULHSU started in DONE, then start during busy ignored
    issue(F3_MULHSU, 1'b1, 1'b1, 1'b0);
    expect_out("b2b_load", MUX_R_A, MUX_D_B, MUX_Z_ZERO, MUX_MULTA_ZERO, MUX_MULTB_ZERO,
               1'b1, 1'b0, 1'b0, 1'b0);
    funct3 = F3_DIVU; start = 1'b1;
    tick();
    expect_out("b2b_ops", MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP, MUX_MULTA_SIGNED,
               MUX_MULTB_UNSIGNED, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("b2b_prod_busy", 32'(busy), 32'(1'b1));
    tick();
    expect_out("b2b_wb", MUX_R_KEEP, MUX_D_KEEP, MUX_Z_MULT_UPPER, MUX_MULTA_SIGNED,
               MUX_MULTB_UNSIGNED, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    expect_out("b2b_done", MUX_R_KEEP, MUX_D_KEEP, MUX_Z_KEEP, MUX_MULTA_ZERO,
               MUX_MULTB_ZERO, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expect_idle("b2b_after");

    // Reset in the middle of a divide aborts at once
    issue(F3_DIV, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    expect_idle("midop_reset");
    reset = 1'b0;
    tick();
    expect_idle("midop_reset_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
